// File: rtl/alu_seq.sv
// alu_seq: registered arithmetic unit shared between the operand register
// file and writeback. Single-cycle ops update y/flags one clock after start
// is sampled; MUL iterates shift-add for WIDTH clocks with busy held high.
//
// Ports:
//   clk, rst_n          rising-edge clock, asynchronous active-low reset
//   start               request, sampled only while idle
//   a, b                operands; b[$clog2(WIDTH)-1:0] is the shift amount
//   sel                 opcode
//   y                   registered result (CMP leaves it unchanged)
//   carry/zero/neg/ovf  registered flags
//   busy                high while MUL iterates
//   done                one-cycle pulse whenever y/flags are written
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       sel,
  output logic [WIDTH-1:0] y,
  output logic             carry,
  output logic             zero,
  output logic             neg,
  output logic             ovf,
  output logic             busy,
  output logic             done
);

  localparam int SW  = $clog2(WIDTH);
  localparam int MSB = WIDTH - 1;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_NOT  = 4'b0101;
  localparam logic [3:0] OP_INC  = 4'b0110;
  localparam logic [3:0] OP_DEC  = 4'b0111;
  localparam logic [3:0] OP_SHL  = 4'b1000;
  localparam logic [3:0] OP_SHR  = 4'b1001;
  localparam logic [3:0] OP_SAR  = 4'b1010;
  localparam logic [3:0] OP_ROL  = 4'b1011;
  localparam logic [3:0] OP_MUL  = 4'b1100;
  localparam logic [3:0] OP_ADC  = 4'b1101;
  localparam logic [3:0] OP_CMP  = 4'b1110;
  localparam logic [3:0] OP_PASS = 4'b1111;

  typedef enum logic {
    S_IDLE,
    S_MUL
  } state_t;

  state_t             state_q;
  logic [WIDTH-1:0]   y_q;
  logic               carry_q, zero_q, neg_q, ovf_q, busy_q, done_q;
  logic [WIDTH-1:0]   aLat_q, bLat_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [SW-1:0]      count_q;

  logic [WIDTH-1:0]   res_d;
  logic               carry_d, ovf_d;
  logic [WIDTH:0]     ext;
  logic [WIDTH:0]     shw;
  logic [SW-1:0]      sh;
  logic [2*WIDTH-1:0] term, acc_d;

  assign sh = b[SW-1:0];

  // Single-cycle datapath. Shifts are done one bit wider than the operand so
  // the last bit shifted out lands in the extra bit; with sh==0 that bit is
  // the padding zero, giving carry=0 for free.
  always_comb begin
    res_d   = '0;
    carry_d = 1'b0;
    ovf_d   = 1'b0;
    ext     = '0;
    shw     = '0;
    case (sel)
      OP_ADD: begin
        ext     = {1'b0, a} + {1'b0, b};
        res_d   = ext[MSB:0];
        carry_d = ext[WIDTH];
        ovf_d   = (a[MSB] == b[MSB]) && (ext[MSB] != a[MSB]);
      end
      OP_ADC: begin
        ext     = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, carry_q};
        res_d   = ext[MSB:0];
        carry_d = ext[WIDTH];
        ovf_d   = (a[MSB] == b[MSB]) && (ext[MSB] != a[MSB]);
      end
      OP_SUB, OP_CMP: begin
        ext     = {1'b0, a} - {1'b0, b};
        res_d   = ext[MSB:0];
        carry_d = ext[WIDTH];
        ovf_d   = (a[MSB] != b[MSB]) && (ext[MSB] != a[MSB]);
      end
      OP_INC: begin
        ext     = {1'b0, a} + (WIDTH+1)'(1);
        res_d   = ext[MSB:0];
        carry_d = ext[WIDTH];
        ovf_d   = !a[MSB] && ext[MSB];
      end
      OP_DEC: begin
        ext     = {1'b0, a} - (WIDTH+1)'(1);
        res_d   = ext[MSB:0];
        carry_d = ext[WIDTH];
        ovf_d   = a[MSB] && !ext[MSB];
      end
      OP_AND:  res_d = a & b;
      OP_OR:   res_d = a | b;
      OP_XOR:  res_d = a ^ b;
      OP_NOT:  res_d = ~a;
      OP_PASS: res_d = b;
      OP_SHL: begin
        shw     = {1'b0, a} << sh;
        res_d   = shw[MSB:0];
        carry_d = shw[WIDTH];
      end
      OP_SHR: begin
        shw     = {a, 1'b0} >> sh;
        res_d   = shw[WIDTH:1];
        carry_d = shw[0];
      end
      OP_SAR: begin
        shw     = $unsigned($signed({a, 1'b0}) >>> sh);
        res_d   = shw[WIDTH:1];
        carry_d = shw[0];
      end
      OP_ROL:  res_d = (a << sh) | (a >> (WIDTH - int'(sh)));
      default: res_d = '0;
    endcase
  end

  // One shift-add step: add the latched multiplicand shifted by the current
  // bit position when that multiplier bit is set.
  always_comb begin
    term  = bLat_q[count_q] ? ({{WIDTH{1'b0}}, aLat_q} << count_q) : '0;
    acc_d = acc_q + term;
  end

  // Control FSM with all outputs registered. done defaults low so it only
  // pulses on the cycle after a write to y/flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      y_q     <= '0;
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
      neg_q   <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      aLat_q  <= '0;
      bLat_q  <= '0;
      acc_q   <= '0;
      count_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            if (sel == OP_MUL) begin
              aLat_q  <= a;
              bLat_q  <= b;
              acc_q   <= '0;
              count_q <= '0;
              busy_q  <= 1'b1;
              state_q <= S_MUL;
            end else begin
              if (sel != OP_CMP) begin
                y_q <= res_d;
              end
              carry_q <= carry_d;
              zero_q  <= (res_d == '0);
              neg_q   <= res_d[MSB];
              ovf_q   <= ovf_d;
              done_q  <= 1'b1;
            end
          end
        end
        S_MUL: begin
          acc_q   <= acc_d;
          count_q <= count_q + SW'(1);
          if (count_q == SW'(WIDTH - 1)) begin
            y_q     <= acc_d[MSB:0];
            carry_q <= |acc_d[2*WIDTH-1:WIDTH];
            zero_q  <= (acc_d[MSB:0] == '0);
            neg_q   <= acc_d[MSB];
            ovf_q   <= 1'b0;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign y     = y_q;
  assign carry = carry_q;
  assign zero  = zero_q;
  assign neg   = neg_q;
  assign ovf   = ovf_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, registered successor to the team's 4-bit combinational ALU. Adds a start/busy/done handshake, registered result and flags, a carry-chained add, barrel shifts and rotate, a compare, and an iterative multi-cycle multiply. Sits between the operand register file and writeback as the shared arithmetic unit; single-cycle ops complete in one clock, MUL takes WIDTH clocks.

## Interface
- WIDTH, 8: operand/result width. Must be a power of 2 and ≥4.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request; sampled only when not busy
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B; the low $clog2(WIDTH) bits give the shift amount for shift/rotate ops
- sel  in  4  opcode
- y  out  WIDTH  registered result
- carry  out  1  registered carry/borrow flag
- zero  out  1  registered result==0 flag
- neg  out  1  registered result MSB
- ovf  out  1  registered signed-overflow flag
- busy  out  1  high while MUL iterates
- done  out  1  one-cycle pulse when the result/flags update

## Operation
- Opcodes 0000–0111 keep the legacy encoding:
  - 0000 ADD a+b
  - 0001 SUB a−b
  - 0010 AND
  - 0011 OR
  - 0100 XOR
  - 0101 NOT a
  - 0110 INC a
  - 0111 DEC a
- New opcodes:
  - 1000 SHL a by sh
  - 1001 SHR logical
  - 1010 SAR arithmetic
  - 1011 ROL
  - 1100 MUL, low WIDTH bits of a*b, unsigned
  - 1101 ADC a+b+carry (uses the current registered carry)
  - 1110 CMP a−b: flags only, y holds
  - 1111 PASS b
- carry:
  - ADD/ADC/INC: carry-out.
  - SUB/CMP: borrow (a<b unsigned).
  - DEC: borrow (a==0).
  - SHL/SHR/SAR: last bit shifted out; 0 when sh==0.
  - MUL: 1 iff the high WIDTH bits of the product are nonzero.
  - All other ops: 0.
- ovf: two's-complement overflow for ADD, SUB, ADC, INC, DEC and CMP; 0 for all other ops.
- zero/neg: computed on the full op result, including CMP's internal difference.
- FSM states:
  - IDLE: on start, any non-MUL op → registers update, stays IDLE. MUL → latch a, b; clear the accumulator; count=0; go to MUL.
  - MUL: one shift-add iteration per clock, count increments. When count==WIDTH−1, write y/flags, pulse done, return to IDLE.
- MUL datapath: 2*WIDTH-bit accumulator so carry can be derived.
- start while busy is ignored. Input changes during MUL do not affect the result, because operands are latched.
- done is never asserted without a register update.

## Timing
- Reset (async assert, sync release): y=0, carry=0, zero=0, neg=0, ovf=0, busy=0, done=0, state=IDLE.
- Non-MUL op with start sampled at edge k:
  - y/flags valid after edge k.
  - done high for exactly the cycle following edge k.
  - Back-to-back starts on consecutive edges are legal; each one produces its own done pulse.
- MUL with start sampled at edge k:
  - busy=1 from after edge k until after edge k+WIDTH.
  - y/flags update and done=1 after edge k+WIDTH.
  - The next start is accepted at edge k+WIDTH+1 or later.
- ADC back-to-back: ADC uses the carry produced by the immediately preceding completed op.
- Reset mid-MUL: aborts immediately, all outputs return to their reset values, no done is produced.

## Test plan
- WIDTH=8, ADD 0xF0+0x20 → y=0x10, carry=1, ovf=0; done high exactly one cycle after the start edge, busy stays 0.
- ADD 0x7F+0x01 → y=0x80, ovf=1, neg=1. Then SUB 0x03−0x05 → y=0xFE, carry=1. Then ADC 0x01+0x01 → y=0x03. Then CMP 0x05,0x05 → zero=1, carry=0, y remains 0x03.
- SHL 0x81 by 1 → y=0x02, carry=1. SAR 0x80 by 3 → y=0xF0. ROL 0x81 by 4 → y=0x18, carry=0. SHR 0x01 by 0 → y=0x01, carry=0.
- MUL 0x0F*0x11 → busy for 8 cycles, then y=0xFF, carry=0, done. MUL 0x10*0x10 → y=0x00, zero=1, carry=1. A start pulsed with a new op during busy is ignored.
- Assert rst_n=0 on the 4th cycle of a MUL → all outputs 0 at once, no done. After release, INC 0xFF → y=0x00, carry=1, zero=1.
